// File: rtl/prv_trap_pkg.sv
// Shared types for the privileged trap sequencer: FSM states, the captured trap
// record, and the xtvec mode encoding.
package prv_trap_pkg;

    localparam int CAUSE_W_DEF = 5;
    localparam int XLEN_DEF    = 32;

    // xtvec[1:0] value that selects vectored interrupt dispatch
    localparam logic [1:0] TVEC_MODE_VECTORED = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        XFLUSH,
        COMMIT,
        XCOMMIT,
        REDIRECT
    } trap_state_t;

    // Record widths track the package defaults; an instance overriding XLEN or
    // CAUSE_W must be paired with matching defaults here.
    typedef struct packed {
        logic                   is_int;
        logic [CAUSE_W_DEF-1:0] cause;
        logic [XLEN_DEF-1:0]    epc;
        logic [XLEN_DEF-1:0]    tval;
    } trap_rec_t;

endpackage

// File: rtl/prv_trap_select.sv
// Combinational precedence picker: oldest exception first, then the
// highest-index pending interrupt when interrupts are globally enabled.
module prv_trap_select
    import prv_trap_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int NUM_INT = 3,
    parameter int CAUSE_W = CAUSE_W_DEF,
    parameter int XLEN    = XLEN_DEF
) (
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC*CAUSE_W-1:0] src_cause,
    input  logic [NUM_SRC*XLEN-1:0]    src_epc,
    input  logic [NUM_SRC*XLEN-1:0]    src_tval,
    input  logic [NUM_INT-1:0]         int_pending,
    input  logic                       int_global_en,
    input  logic [NUM_INT*CAUSE_W-1:0] int_cause,
    input  logic [XLEN-1:0]            commit_pc,
    output trap_rec_t                  rec,
    output logic                       valid
);

    // Later assignments override earlier ones, so the loop order encodes the
    // precedence: interrupts ascend (highest index wins), exceptions descend
    // (lowest index wins) and are applied last so they beat any interrupt.
    always_comb begin
        // NOTE: every output gets a default first, so no path infers a latch.
        rec   = '0;
        valid = 1'b0;
        if (int_global_en) begin
            for (int i = 0; i < NUM_INT; i++) begin
                if (int_pending[i]) begin
                    rec.is_int = 1'b1;
                    rec.cause  = int_cause[i*CAUSE_W +: CAUSE_W];
                    rec.epc    = commit_pc;
                    rec.tval   = '0;
                    valid      = 1'b1;
                end
            end
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) begin
                rec.is_int = 1'b0;
                rec.cause  = src_cause[i*CAUSE_W +: CAUSE_W];
                rec.epc    = src_epc[i*XLEN +: XLEN];
                rec.tval   = src_tval[i*XLEN +: XLEN];
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Trap/xRET sequencer: picks one trap, flushes the pipeline, strobes the CSR
// update, then redirects fetch and waits for the fetch handshake.
module prv_trap_sequencer
    import prv_trap_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int NUM_INT = 3,
    parameter int CAUSE_W = CAUSE_W_DEF,
    parameter int XLEN    = XLEN_DEF
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC*CAUSE_W-1:0] src_cause,
    input  logic [NUM_SRC*XLEN-1:0]    src_epc,
    input  logic [NUM_SRC*XLEN-1:0]    src_tval,
    input  logic [NUM_INT-1:0]         int_pending,
    input  logic                       int_global_en,
    input  logic [NUM_INT*CAUSE_W-1:0] int_cause,
    input  logic [XLEN-1:0]            commit_pc,
    input  logic                       mret,
    input  logic                       sret,
    input  logic [XLEN-1:0]            xtvec,
    input  logic [XLEN-1:0]            xepc,
    input  logic                       pipe_drained,
    input  logic                       fetch_ack,
    output logic                       pipe_clear,
    output logic                       insert_pc,
    output logic [XLEN-1:0]            priv_pc,
    output logic                       trap_commit,
    output logic                       trap_is_int,
    output logic [CAUSE_W-1:0]         trap_cause,
    output logic [XLEN-1:0]            trap_epc,
    output logic [XLEN-1:0]            trap_tval,
    output logic                       xret_commit,
    output logic                       busy
);

    trap_state_t     state_q, state_d;
    trap_rec_t       rec_q, rec_d;
    logic [XLEN-1:0] target_q, target_d;

    trap_rec_t       sel_rec;
    logic            sel_valid;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] tvec_target;

    prv_trap_select #(
        .NUM_SRC (NUM_SRC),
        .NUM_INT (NUM_INT),
        .CAUSE_W (CAUSE_W),
        .XLEN    (XLEN)
    ) u_select (
        .src_valid     (src_valid),
        .src_cause     (src_cause),
        .src_epc       (src_epc),
        .src_tval      (src_tval),
        .int_pending   (int_pending),
        .int_global_en (int_global_en),
        .int_cause     (int_cause),
        .commit_pc     (commit_pc),
        .rec           (sel_rec),
        .valid         (sel_valid)
    );

    // Vectored dispatch applies to interrupts only; the add wraps at XLEN.
    always_comb begin
        tvec_base   = {xtvec[XLEN-1:2], 2'b00};
        tvec_target = tvec_base;
        if (xtvec[1:0] == TVEC_MODE_VECTORED && rec_q.is_int) begin
            tvec_target = tvec_base + (XLEN'(rec_q.cause) << 2);
        end
    end

    always_comb begin
        state_d     = state_q;
        rec_d       = rec_q;
        target_d    = target_q;
        pipe_clear  = 1'b0;
        insert_pc   = 1'b0;
        trap_commit = 1'b0;
        xret_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    rec_d   = sel_rec;
                    state_d = FLUSH;
                end else if (mret || sret) begin
                    target_d = xepc;
                    state_d  = XFLUSH;
                end
            end
            FLUSH: begin
                pipe_clear = 1'b1;
                if (pipe_drained) state_d = COMMIT;
            end
            XFLUSH: begin
                pipe_clear = 1'b1;
                if (pipe_drained) state_d = XCOMMIT;
            end
            COMMIT: begin
                pipe_clear  = 1'b1;
                trap_commit = 1'b1;
                target_d    = tvec_target;
                state_d     = REDIRECT;
            end
            XCOMMIT: begin
                pipe_clear  = 1'b1;
                xret_commit = 1'b1;
                state_d     = REDIRECT;
            end
            REDIRECT: begin
                pipe_clear = 1'b1;
                insert_pc  = 1'b1;
                if (fetch_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        priv_pc     = (state_q == REDIRECT) ? target_q : '0;
        trap_is_int = rec_q.is_int;
        trap_cause  = rec_q.cause;
        trap_epc    = rec_q.epc;
        trap_tval   = rec_q.tval;
    end

    // NOTE: state uses non-blocking assignments; reset is sampled on the clock
    // edge and also clears the capture registers so outputs read 0 after reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            rec_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            rec_q    <= rec_d;
            target_q <= target_d;
        end
    end

endmodule
